// File: rtl/xc20xx_clbse_cfg_loader.sv
// Serial loader for XC20XX CLB storage-section configuration records.
// Preamble hunt, record count, 11-bit framed records, legality check, write strobe.
module xc20xx_clbse_cfg_loader #(
    parameter int unsigned NUM_CLB  = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned LEN_W    = 8,
    parameter logic [3:0]  PREAMBLE = 4'b0010
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PROG,
    input  logic              DIN,
    input  logic              DIN_VALID,
    output logic              CFG_WE,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic [8:0]        CFG_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [1:0]        ERR_CODE
);

    localparam int unsigned LW_CW = $clog2(LEN_W + 1);
    localparam int unsigned CNT_W = (LW_CW > 4) ? LW_CW : 4;
    localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(10);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_LEN,
        S_REC,
        S_FIN,
        S_FAIL
    } state_t;

    state_t            state;
    logic [2:0]        hunt_sh;
    logic [1:0]        hunt_cnt;
    logic [LEN_W-2:0]  len_sh;
    logic [CNT_W-1:0]  cnt;
    logic [8:0]        rec_sh;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;

    logic [3:0]       hunt_win;
    logic [LEN_W-1:0] n_val;
    logic [31:0]      n_ext;
    logic             len_bad;
    logic             rec_bad;

    assign hunt_win = {hunt_sh, DIN};
    assign n_val    = {len_sh, DIN};
    assign n_ext    = 32'(n_val);
    assign len_bad  = (n_val == '0) || (n_ext > NUM_CLB);

    // A latch has no set/reset path, so both SMUX and RMUX must select GND.
    assign rec_bad = (&rec_sh[7:6]) | (&rec_sh[5:4]) |
                     (&rec_sh[3:2]) | (&rec_sh[1:0]) |
                     (rec_sh[8] & ((rec_sh[7:6] != 2'b10) |
                                   (rec_sh[1:0] != 2'b10)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            hunt_sh  <= '0;
            hunt_cnt <= '0;
            len_sh   <= '0;
            cnt      <= '0;
            rec_sh   <= '0;
            idx      <= '0;
            last_idx <= '0;
            CFG_WE   <= 1'b0;
            CFG_ADDR <= '0;
            CFG_DATA <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= 2'b00;
        end else begin
            CFG_WE <= 1'b0;
            if (PROG) begin
                state    <= S_HUNT;
                hunt_cnt <= '0;
                cnt      <= '0;
                idx      <= '0;
                CFG_ADDR <= '0;
                BUSY     <= 1'b1;
                DONE     <= 1'b0;
                ERR      <= 1'b0;
                ERR_CODE <= 2'b00;
            end else if (DIN_VALID) begin
                unique case (state)
                    S_HUNT: begin
                        hunt_sh <= hunt_win[2:0];
                        if (hunt_cnt != 2'd3)
                            hunt_cnt <= hunt_cnt + 2'd1;
                        // Only compare once four fresh bits are in the window.
                        if (hunt_cnt == 2'd3 && hunt_win == PREAMBLE) begin
                            state <= S_LEN;
                            cnt   <= '0;
                        end
                    end
                    S_LEN: begin
                        len_sh <= n_val[LEN_W-2:0];
                        cnt    <= cnt + 1'b1;
                        if (cnt == LEN_LAST) begin
                            cnt <= '0;
                            if (len_bad) begin
                                state    <= S_FAIL;
                                BUSY     <= 1'b0;
                                ERR      <= 1'b1;
                                ERR_CODE <= 2'b01;
                            end else begin
                                state    <= S_REC;
                                idx      <= '0;
                                last_idx <= ADDR_W'(n_ext - 32'd1);
                            end
                        end
                    end
                    S_REC: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) begin
                            if (DIN) begin
                                state    <= S_FAIL;
                                BUSY     <= 1'b0;
                                ERR      <= 1'b1;
                                ERR_CODE <= 2'b10;
                            end
                        end else if (cnt == REC_LAST) begin
                            cnt <= '0;
                            if (!DIN) begin
                                state    <= S_FAIL;
                                BUSY     <= 1'b0;
                                ERR      <= 1'b1;
                                ERR_CODE <= 2'b10;
                            end else if (rec_bad) begin
                                state    <= S_FAIL;
                                BUSY     <= 1'b0;
                                ERR      <= 1'b1;
                                ERR_CODE <= 2'b11;
                            end else begin
                                CFG_WE   <= 1'b1;
                                CFG_DATA <= rec_sh;
                                CFG_ADDR <= idx;
                                idx      <= idx + 1'b1;
                                if (idx == last_idx) begin
                                    state <= S_FIN;
                                    BUSY  <= 1'b0;
                                    DONE  <= 1'b1;
                                end
                            end
                        end else begin
                            rec_sh <= {rec_sh[7:0], DIN};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xc20xx_clbse_cfg_loader.sv
// Directed bench for the CLB storage-section config loader.
// Expected writes go to a scoreboard queue; a negedge monitor pops and compares.
module tb_xc20xx_clbse_cfg_loader;

    localparam int NUM_CLB = 64;
    localparam int ADDR_W  = 6;
    localparam int LEN_W   = 8;

    localparam logic [8:0] R0 = 9'b0_01_00_00_00;
    localparam logic [8:0] R1 = 9'b1_10_01_01_10;
    localparam logic [8:0] R2 = 9'b0_00_01_10_01;

    logic              CLK = 1'b0;
    logic              RST;
    logic              PROG;
    logic              DIN;
    logic              DIN_VALID;
    logic              CFG_WE;
    logic [ADDR_W-1:0] CFG_ADDR;
    logic [8:0]        CFG_DATA;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [1:0]        ERR_CODE;

    int tests = 0;
    int fails = 0;
    bit toggle = 1'b0;
    logic [ADDR_W+8:0] sb[$];

    xc20xx_clbse_cfg_loader #(
        .NUM_CLB (NUM_CLB),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .PREAMBLE(4'b0010)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PROG     (PROG),
        .DIN      (DIN),
        .DIN_VALID(DIN_VALID),
        .CFG_WE   (CFG_WE),
        .CFG_ADDR (CFG_ADDR),
        .CFG_DATA (CFG_DATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [ADDR_W+8:0] e;
        if (RST === 1'b0 && CFG_WE === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected none",
                       CFG_ADDR, CFG_DATA);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(CFG_ADDR), 32'(e[ADDR_W+8:9]));
                check("wr_data", 32'(CFG_DATA), 32'(e[8:0]));
            end
        end
    end

    task automatic send_bit(input logic b);
        if (toggle) begin
            DIN = ~b;
            DIN_VALID = 1'b0;
            @(posedge CLK);
            #1;
        end
        DIN = b;
        DIN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
    endtask

    task automatic send_preamble();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
    endtask

    task automatic send_len(input int n);
        for (int i = LEN_W - 1; i >= 0; i--) send_bit(n[i]);
    endtask

    task automatic send_rec(input logic [8:0] d, input logic st,
                            input logic sp);
        send_bit(st);
        for (int i = 8; i >= 0; i--) send_bit(d[i]);
        send_bit(sp);
    endtask

    task automatic push(input int a, input logic [8:0] d);
        sb.push_back({a[ADDR_W-1:0], d});
    endtask

    task automatic do_prog();
        PROG = 1'b1;
        DIN = 1'b1;
        DIN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        PROG = 1'b0;
        DIN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic status(input string tag, input logic busy, input logic done,
                          input logic err, input logic [1:0] code);
        check({tag, "_busy"}, 32'(BUSY), 32'(busy));
        check({tag, "_done"}, 32'(DONE), 32'(done));
        check({tag, "_err"}, 32'(ERR), 32'(err));
        check({tag, "_code"}, 32'(ERR_CODE), 32'(code));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        PROG = 1'b0;
        DIN = 1'b0;
        DIN_VALID = 1'b0;
        idle(2);
        check("rst_we", 32'(CFG_WE), 32'd0);
        check("rst_addr", 32'(CFG_ADDR), 32'd0);
        check("rst_data", 32'(CFG_DATA), 32'd0);
        status("rst", 1'b0, 1'b0, 1'b0, 2'b00);
        RST = 1'b0;

        // Nominal two-record load
        do_prog();
        check("prog_busy", 32'(BUSY), 32'd1);
        send_preamble();
        send_len(2);
        check("len_busy", 32'(BUSY), 32'd1);
        push(0, R0);
        send_rec(R0, 1'b0, 1'b1);
        check("lat_we", 32'(CFG_WE), 32'd1);
        check("lat_addr", 32'(CFG_ADDR), 32'd0);
        push(1, R1);
        send_rec(R1, 1'b0, 1'b1);
        idle(3);
        status("nom", 1'b0, 1'b1, 1'b0, 2'b00);
        check("nom_addr", 32'(CFG_ADDR), 32'd1);
        check("nom_data", 32'(CFG_DATA), 32'(R1));
        send_preamble();
        idle(2);
        status("fin_hold", 1'b0, 1'b1, 1'b0, 2'b00);

        // Same stream with DIN_VALID gaps
        toggle = 1'b1;
        do_prog();
        send_preamble();
        send_len(2);
        push(0, R0);
        send_rec(R0, 1'b0, 1'b1);
        push(1, R1);
        send_rec(R1, 1'b0, 1'b1);
        idle(3);
        status("gap", 1'b0, 1'b1, 1'b0, 2'b00);
        toggle = 1'b0;

        // Bad lengths
        do_prog();
        send_preamble();
        send_len(0);
        send_rec(R0, 1'b0, 1'b1);
        idle(2);
        status("n0", 1'b0, 1'b0, 1'b1, 2'b01);

        do_prog();
        send_preamble();
        send_len(NUM_CLB + 1);
        send_rec(R0, 1'b0, 1'b1);
        idle(2);
        status("nbig", 1'b0, 1'b0, 1'b1, 2'b01);

        do_prog();
        send_preamble();
        send_len(NUM_CLB);
        idle(1);
        status("nmax", 1'b1, 1'b0, 1'b0, 2'b00);

        // Framing errors
        do_prog();
        send_preamble();
        send_len(2);
        push(0, R0);
        send_rec(R0, 1'b0, 1'b1);
        send_rec(R1, 1'b0, 1'b0);
        idle(2);
        status("stop0", 1'b0, 1'b0, 1'b1, 2'b10);

        do_prog();
        send_preamble();
        send_len(1);
        send_rec(R0, 1'b1, 1'b1);
        idle(2);
        status("start1", 1'b0, 1'b0, 1'b1, 2'b10);

        // Illegal records
        do_prog();
        send_preamble();
        send_len(1);
        send_rec(9'b0_11_00_00_00, 1'b0, 1'b1);
        idle(2);
        status("smux11", 1'b0, 1'b0, 1'b1, 2'b11);

        do_prog();
        send_preamble();
        send_len(1);
        send_rec(9'b1_10_00_00_00, 1'b0, 1'b1);
        idle(2);
        status("latch_r", 1'b0, 1'b0, 1'b1, 2'b11);

        // Restart mid-record
        do_prog();
        send_preamble();
        send_len(3);
        push(0, R0);
        send_rec(R0, 1'b0, 1'b1);
        push(1, R1);
        send_rec(R1, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_prog_addr", 32'(CFG_ADDR), 32'd1);
        do_prog();
        check("prog_addr", 32'(CFG_ADDR), 32'd0);
        send_preamble();
        send_len(1);
        push(0, R2);
        send_rec(R2, 1'b0, 1'b1);
        idle(3);
        status("restart", 1'b0, 1'b1, 1'b0, 2'b00);
        check("restart_addr", 32'(CFG_ADDR), 32'd0);

        // Reset mid-record
        do_prog();
        send_preamble();
        send_len(2);
        push(0, R1);
        send_rec(R1, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        RST = 1'b1;
        idle(1);
        check("mrst_we", 32'(CFG_WE), 32'd0);
        check("mrst_addr", 32'(CFG_ADDR), 32'd0);
        check("mrst_data", 32'(CFG_DATA), 32'd0);
        status("mrst", 1'b0, 1'b0, 1'b0, 2'b00);
        RST = 1'b0;
        send_preamble();
        send_len(1);
        send_rec(R0, 1'b0, 1'b1);
        idle(2);
        status("idle_ign", 1'b0, 1'b0, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xc20xx_clbse_cfg_loader.md
Name: xc20xx_clbse_cfg_loader

Overview:
Bit-serial configuration controller for the CLB storage sections of an XC20XX array. It hunts for a preamble, reads a record count, then deframes one 9-bit storage-element record per CLB. It validates each record against the SMUX/CLKINMUX/CLKPOLMUX/RMUX/MODE encodings and writes legal records into the per-CLB config store. It sits between the configuration pin interface and the CLB config memory, and drives BUSY/DONE/ERR status to the device-level sequencer.

Parameters:
NUM_CLB, 64, number of CLB storage sections in the array (>=1)
ADDR_W, 6, width of CFG_ADDR; 2**ADDR_W >= NUM_CLB
LEN_W, 8, width of the record-count field in the stream
PREAMBLE, 4'b0010, sync pattern; the first bit received is the MSB

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST  input  1  synchronous, active-high reset
PROG  input  1  one-cycle start/restart request
DIN  input  1  serial configuration data
DIN_VALID  input  1  DIN is sampled only on cycles where this is high
CFG_WE  output  1  one-cycle write strobe to the config store
CFG_ADDR  output  ADDR_W  CLB index being written
CFG_DATA  output  9  record {MODE, SMUX[1:0], CLKIN[1:0], CLKPOL[1:0], RMUX[1:0]}
BUSY  output  1  high in HUNT/LEN/REC states
DONE  output  1  sticky; all records written without error
ERR  output  1  sticky; load aborted
ERR_CODE  output  2  00 none, 01 bad length, 10 framing, 11 illegal record

Behaviour:
- Reset (RST=1 at edge): state IDLE; CFG_WE=0, CFG_ADDR=0, CFG_DATA=0, BUSY=0, DONE=0, ERR=0, ERR_CODE=00. RST has priority over PROG.
- States: IDLE, HUNT, LEN, REC, FIN, FAIL. Only HUNT, LEN and REC consume bits, and only when DIN_VALID=1. With DIN_VALID=0, state and counters hold.
- PROG=1 in any state: go to HUNT; clear DONE, ERR, ERR_CODE, CFG_ADDR and the bit counters. Any bit presented in that same cycle is ignored.
- HUNT: a 4-bit shift register is compared after each shift. On match, go to LEN. Overlapping matches are allowed, e.g. stream 0 0 1 0 matches on the 4th valid bit.
- LEN: shift in LEN_W bits, MSB first, to form N. When the last bit arrives:
  - N==0 or N>NUM_CLB: FAIL, code 01.
  - Otherwise: REC.
- REC: each record is 11 bits: start bit (must be 0), 9 data bits MSB first, stop bit (must be 1).
  - Start=1 or stop=0: FAIL, code 10.
  - Record legality is checked on stop-bit receipt. A record is illegal if:
    - any 2-bit field == 11;
    - MODE=1 (DLATCH) with SMUX!=10 (GND) or RMUX!=10 (GND), because the latch has no set/reset.
  - An illegal record sends the block to FAIL, code 11, with no write.
  - A legal record: CFG_WE=1 for exactly the cycle after the stop bit is sampled, with CFG_DATA=record and CFG_ADDR=record index (0-based). CFG_ADDR then increments.
  - After write N-1, go to FIN.
- Field encodings: SMUX 00=A 01=F 10=GND; CLKIN 00=K 01=C 10=G; CLKPOL 00=true 01=inverted 10=GND; RMUX 00=D 01=G 10=GND; MODE 0=DFF 1=DLATCH.
- FIN: DONE=1, BUSY=0. Stays until RST or PROG. Further DIN is ignored.
- FAIL: ERR=1, BUSY=0, ERR_CODE set. No further writes; stays until RST or PROG.
- CFG_DATA and CFG_ADDR hold their last values when CFG_WE=0. DONE and ERR are never both 1.
- Latency: the first CFG_WE comes 1 cycle after the stop bit of record 0, i.e. at least 4+LEN_W+11 valid bits after HUNT is entered.

Test Plan:
- Reset, PROG, preamble 0010, N=2, two legal records (9'b0_01_00_00_00, 9'b1_10_01_01_10), DIN_VALID always 1 -> writes at addr 0 and 1 with those data, one CFG_WE pulse each, DONE=1, ERR=0.
- Same stream with DIN_VALID toggling 1/0 every cycle -> identical writes and final status; no bits are lost or duplicated.
- N=0, and N=NUM_CLB+1 -> no CFG_WE, ERR=1, ERR_CODE=01, BUSY=0.
- Record 1 with stop bit=0 -> record 0 written, then ERR_CODE=10 with no second write. Separately, start bit=1 -> same code, no write.
- Illegal records: SMUX=11, and DLATCH with RMUX=00 -> ERR_CODE=11, CFG_WE never asserted for that record.
- PROG asserted mid-REC after 1 write, then a full valid N=1 stream -> CFG_ADDR restarts at 0, one write, DONE=1. RST asserted mid-REC -> all outputs return to 0 on the next edge.
